// File: rtl/msrv32_dmem_pkg.sv
// msrv32_dmem_pkg: shared types and constants
// for the MSRV32 data-memory access path.
package msrv32_dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/msrv32_store_lane_gen.sv
// msrv32_store_lane_gen: byte-lane write mask
// and store-data lane replication.
module msrv32_store_lane_gen
  import msrv32_dmem_pkg::*;
(
  input  logic        store,
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2,
  output logic [3:0]  mask,
  output logic [31:0] data
);

  logic is_b;
  logic is_h;
  logic is_w;

  assign is_b = store & (size == LS_BYTE);
  assign is_h = store & (size == LS_HALF);
  assign is_w = store & size[1];

  // lane mask and replicated data per access size
  always_comb begin
    mask = 4'b0000;
    data = rs2;
    unique case (1'b1)
      is_b: begin
        mask = 4'b0001 << addr;
        data = {4{rs2[7:0]}};
      end
      is_h: begin
        mask = 4'b0011 << {addr[1], 1'b0};
        data = {2{rs2[15:0]}};
      end
      is_w: begin
        mask = 4'b1111;
        data = rs2;
      end
      !store: begin
        mask = 4'b0000;
        data = rs2;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_access_ctrl.sv
// msrv32_dmem_access_ctrl: load/store sequencer for the AHB data bus.
// Define MSRV32_DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module msrv32_dmem_access_ctrl
  import msrv32_dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W = 8
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        load_req_in,
  input  logic        store_req_in,
  input  logic [31:0] iadder_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] rs2_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic        ms_riscv32_mp_dmrd_req_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [1:0]  lu_load_size_out,
  output logic        lu_load_unsigned_out,
  output logic [1:0]  lu_iadder_1_to_0_out,
  output logic        lu_ahb_resp_out,
  output logic        stall_out,
  output logic        done_out,
  output logic        bus_err_out,
  output logic        timeout_out
`ifdef MSRV32_DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misaligned_out
`endif
);

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [31:0] addr_q;
  logic [31:0] rs2_q;
  logic [1:0]  a10_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        store_q;
  logic        resp_q;
  logic        to_q;

  logic req;
  logic cap;
  logic cnt_clr;
  logic cnt_inc;
  logic rsp_cap;
  logic to_set;
  logic to_hit;

  assign req = load_req_in | store_req_in;
  assign to_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MSRV32_DMEM_MISALIGN_TRAP_EN
  logic mis_req;
  logic mis_q;

  assign mis_req = ((load_size_in == LS_HALF) & iadder_in[0])
                 | (load_size_in[1] & (|iadder_in[1:0]));
`endif

  // state register
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and datapath strobes
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    rsp_cap = 1'b0;
    to_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          cap = 1'b1;
`ifdef MSRV32_DMEM_MISALIGN_TRAP_EN
          state_d = mis_req ? ST_RESP : ST_ADDR;
`else
          state_d = ST_ADDR;
`endif
        end
      end
      ST_ADDR: begin
        if (ahb_ready_in) begin
          rsp_cap = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_clr = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ahb_ready_in) begin
          rsp_cap = 1'b1;
          state_d = ST_RESP;
        end else if (to_hit) begin
          rsp_cap = 1'b1;
          to_set  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // request capture, wait counter and response capture
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      rs2_q   <= '0;
      a10_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      resp_q  <= 1'b0;
      to_q    <= 1'b0;
`ifdef MSRV32_DMEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      if (cap) begin
        addr_q  <= {iadder_in[31:2], 2'b00};
        a10_q   <= iadder_in[1:0];
        size_q  <= load_size_in;
        uns_q   <= load_unsigned_in;
        rs2_q   <= rs2_in;
        store_q <= store_req_in;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (rsp_cap) begin
        resp_q <= ahb_resp_in | to_set;
        to_q   <= to_set;
      end
`ifdef MSRV32_DMEM_MISALIGN_TRAP_EN
      if (cap) begin
        mis_q <= mis_req;
      end
      if (cap & mis_req) begin
        resp_q <= 1'b0;
        to_q   <= 1'b0;
      end
`endif
    end
  end

  msrv32_store_lane_gen u_lane (
    .store (store_q),
    .size  (size_q),
    .addr  (a10_q),
    .rs2   (rs2_q),
    .mask  (ms_riscv32_mp_dmwr_mask_out),
    .data  (ms_riscv32_mp_dmdata_out)
  );

  assign ms_riscv32_mp_dmaddr_out   = addr_q;
  assign ms_riscv32_mp_dmrd_req_out = (state_q == ST_ADDR) & ~store_q;
  assign ms_riscv32_mp_dmwr_req_out = (state_q == ST_ADDR) & store_q;

  assign lu_load_size_out     = size_q;
  assign lu_load_unsigned_out = uns_q;
  assign lu_iadder_1_to_0_out = a10_q;
  assign lu_ahb_resp_out      = resp_q;

  assign stall_out = ((state_q == ST_IDLE) & req)
                   | (state_q == ST_ADDR)
                   | (state_q == ST_WAIT);

  assign done_out    = (state_q == ST_RESP);
  assign bus_err_out = (state_q == ST_RESP) & resp_q;
  assign timeout_out = (state_q == ST_RESP) & to_q;

`ifdef MSRV32_DMEM_MISALIGN_TRAP_EN
  assign misaligned_out = (state_q == ST_RESP) & mis_q;
`endif

endmodule
